// File: rtl/core_pkg.sv
// core_pkg: shared fetch FSM state encoding and AXI response codes
package core_pkg;
   typedef enum logic [1:0] {IDLE, AR, R} fetch_state_t;
   localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/core_sync_fifo.sv
// core_sync_fifo: power-of-two synchronous FIFO with flush; flush beats push and pop
module core_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0] cnt;
   logic do_push, do_pop;
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign empty   = cnt == '0;
   assign full    = cnt == (AW+1)'(DEPTH);
   assign rdata   = mem[rd_ptr];
   // storage array; contents need no reset since cnt gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
   // pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
         cnt    <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/core_ifetch_pf.sv
// core_ifetch_pf: AXI read instruction prefetcher with redirect; IFETCH_RRESP_CHECK_EN enables sticky RRESP error trapping
module core_ifetch_pf
   import core_pkg::*;
#(
   parameter int                    AXI_AWIDTH = 32,
   parameter int                    AXI_DWIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [AXI_AWIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  CLK,
   input  logic                  RST,
   output logic [AXI_AWIDTH-1:0] AXI_ARADDR,
   output logic                  AXI_ARVALID,
   input  logic                  AXI_ARREADY,
   input  logic [AXI_DWIDTH-1:0] AXI_RDATA,
   input  logic [1:0]            AXI_RRESP,
   input  logic                  AXI_RVALID,
   output logic                  AXI_RREADY,
   input  logic                  REDIRECT,
   input  logic [AXI_AWIDTH-1:0] REDIRECT_PC,
   output logic                  INSTR_VALID,
   input  logic                  INSTR_READY,
   output logic [AXI_DWIDTH-1:0] INSTRUCTION,
   output logic [AXI_AWIDTH-1:0] INSTR_PC,
   output logic                  BUSY,
   output logic                  FETCH_ERR
);
   fetch_state_t state, state_nxt;
   logic [AXI_AWIDTH-1:0] fetch_pc, req_addr;
   logic [AXI_DWIDTH+AXI_AWIDTH-1:0] head;
   logic discard, fifo_empty, fifo_full, ar_hs, r_hs, push, issue, resp_err, fetch_err;
   logic unused_pc_lsb;
   assign unused_pc_lsb = ^REDIRECT_PC[1:0];
   assign ar_hs       = (state == AR) & AXI_ARREADY;
   assign r_hs        = (state == R) & AXI_RVALID;
   assign issue       = ~fifo_full & ~fetch_err & ~REDIRECT;
   assign push        = r_hs & ~discard & ~REDIRECT & ~resp_err;
   assign AXI_ARVALID = state == AR;
   assign AXI_RREADY  = state == R;
   assign BUSY        = state != IDLE;
   assign AXI_ARADDR  = (state == AR) ? req_addr : fetch_pc;
   assign INSTR_VALID = ~fifo_empty;
   assign {INSTRUCTION, INSTR_PC} = head;
   assign FETCH_ERR   = fetch_err;
`ifdef IFETCH_RRESP_CHECK_EN
   assign resp_err = AXI_RRESP != RESP_OKAY;
   // sticky error on a live beat with bad response; only a redirect clears it
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) fetch_err <= 1'b0;
      else if (REDIRECT) fetch_err <= 1'b0;
      else if (r_hs && !discard && resp_err) fetch_err <= 1'b1;
   end
`else
   logic unused_rresp;
   assign unused_rresp = ^AXI_RRESP;
   assign resp_err     = 1'b0;
   assign fetch_err    = 1'b0;
`endif
   // FSM state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else state <= state_nxt;
   end
   // next state: one read in flight, issue only when a buffer slot is free
   always_comb begin
      state_nxt = state;
      state_nxt = (state == IDLE) ? (issue ? AR : IDLE) :
                  (state == AR)   ? (AXI_ARREADY ? R : AR) :
                                    (AXI_RVALID ? IDLE : R);
   end
   // fetch pointer, in-flight address and discard flag for redirected transactions
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
         discard  <= 1'b0;
      end else begin
         if (REDIRECT) fetch_pc <= {REDIRECT_PC[AXI_AWIDTH-1:2], 2'b00};
         else if (ar_hs && !discard) fetch_pc <= fetch_pc + AXI_AWIDTH'(4);
         if (state == IDLE) req_addr <= fetch_pc;
         discard <= r_hs ? 1'b0 : (REDIRECT && state != IDLE) ? 1'b1 : discard;
      end
   end
   core_sync_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(AXI_DWIDTH + AXI_AWIDTH)
   ) u_buf (
      .clk  (CLK),
      .rst  (RST),
      .flush(REDIRECT),
      .push (push),
      .wdata({AXI_RDATA, req_addr}),
      .pop  (INSTR_READY),
      .rdata(head),
      .empty(fifo_empty),
      .full (fifo_full)
   );
endmodule

// File: doc/core_ifetch_pf.md
CORE_IFETCH_PF -- requirements
Module: core_ifetch_pf

Interface
REQ-001 SHALL have parameter AXI_AWIDTH, default 32, meaning instruction address width.
REQ-002 SHALL have parameter AXI_DWIDTH, default 32, meaning instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning prefetch buffer entries (power of 2, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-005 SHALL have ports:
- CLK  in  1  clock; one clock domain
- RST  in  1  reset; asynchronous, active-high
- AXI_ARADDR  out  AXI_AWIDTH  fetch address
- AXI_ARVALID  out  1  address valid
- AXI_ARREADY  in  1  address accepted
- AXI_RDATA  in  AXI_DWIDTH  fetched word
- AXI_RRESP  in  2  read response
- AXI_RVALID  in  1  data valid
- AXI_RREADY  out  1  data accept
- REDIRECT  in  1  one-cycle pulse: flush and restart at REDIRECT_PC
- REDIRECT_PC  in  AXI_AWIDTH  new fetch address; bits [1:0] ignored
- INSTR_VALID  out  1  buffer head valid
- INSTR_READY  in  1  consumer pops head
- INSTRUCTION  out  AXI_DWIDTH  head word
- INSTR_PC  out  AXI_AWIDTH  head word address
- BUSY  out  1  AR or R transaction in flight
- FETCH_ERR  out  1  sticky fetch error

Function
REQ-006 SHALL use FSM states IDLE, AR, R; at most one AXI read in flight.
REQ-007 SHALL go IDLE->AR when buffer count < DEPTH and FETCH_ERR=0; AXI_ARADDR=fetch_pc, AXI_ARVALID=1.
REQ-008 SHALL hold AXI_ARVALID and AXI_ARADDR stable in AR until AXI_ARREADY, REDIRECT notwithstanding.
REQ-009 SHALL on AR handshake go to R, advance fetch_pc by 4 (modulo 2^AXI_AWIDTH wrap).
REQ-010 SHALL drive AXI_RREADY=1 throughout R; on RVALID&RREADY go to IDLE.
REQ-011 SHALL push {RDATA, address} into the buffer on the R handshake unless the discard flag is set; INSTR_VALID rises the following cycle.
REQ-012 SHALL present buffer head as INSTRUCTION/INSTR_PC with INSTR_VALID=1 when non-empty; pop on INSTR_VALID&INSTR_READY.
REQ-013 SHALL permit push and pop in the same cycle with count unchanged; full buffer blocks new AR (slot reserved at issue, never overflows).
REQ-014 SHALL on REDIRECT: empty buffer, set fetch_pc={REDIRECT_PC[AW-1:2],2'b00}, clear FETCH_ERR; REDIRECT beats simultaneous pop/push.
REQ-015 SHALL on REDIRECT while in AR or R set discard flag; the in-flight response completes on AXI and is dropped; flag clears at that R handshake.
REQ-016 SHALL on REDIRECT coinciding with the R handshake drop that beat.
REQ-017 SHALL assert BUSY in AR and R.
REQ-018 SHALL achieve throughput of one word per 3 cycles with zero-wait slave; latency RVALID handshake to INSTR_VALID is 1 cycle.

Reset
REQ-019 SHALL on RST: state IDLE, buffer empty, fetch_pc=RESET_PC, discard=0, AXI_ARVALID=0, AXI_RREADY=0, AXI_ARADDR=RESET_PC, INSTR_VALID=0, BUSY=0, FETCH_ERR=0.
REQ-020 SHALL on RST mid-transaction abandon it; first AR after release uses RESET_PC.

Configuration
REQ-021 SHALL with macro IFETCH_RRESP_CHECK_EN defined: non-zero AXI_RRESP on a non-discarded beat sets FETCH_ERR, beat not pushed, no further AR until REDIRECT.
REQ-022 SHALL without IFETCH_RRESP_CHECK_EN: RRESP ignored, every non-discarded beat pushed, FETCH_ERR tied 0.

Structure
REQ-023 SHALL place FSM state enum and RESP_OKAY=2'b00 constant in shared package core_pkg.
REQ-024 SHALL instantiate buffer as sub-module core_sync_fifo (DEPTH, width AXI_DWIDTH+AXI_AWIDTH, flush input).

Verification
REQ-025 Reset, ARREADY=RVALID=1 zero-wait, INSTR_READY=1 -> ARADDR 0x0,0x4,0x8 in order; INSTRUCTION/INSTR_PC match memory.
REQ-026 INSTR_READY=0, DEPTH=4 -> exactly 4 ARs issued, then ARVALID stays 0; pop one -> one new AR at next address.
REQ-027 REDIRECT to 0x103 while in R -> in-flight beat dropped, buffer empty, next ARADDR=0x100, first INSTR_PC=0x100.
REQ-028 REDIRECT while AR held with ARREADY=0 -> ARADDR unchanged until handshake, response dropped, then AR to new PC.
REQ-029 IFETCH_RRESP_CHECK_EN, RRESP=2'b10 at 0x8 -> FETCH_ERR=1, no push, no AR; REDIRECT 0x0 -> FETCH_ERR=0, fetch resumes.
REQ-030 fetch_pc=0xFFFFFFFC -> next ARADDR=0x00000000.
